// File: rtl/bist_sequencer_if.sv
// -----------------------------------------------------------------------------
// bist_sequencer_if
//   Signal bundle between the BIST sequencer, the host that requests a run and
//   the BIST engine that executes the individual tests.
//
//   start      host -> sequencer   one-cycle request to run the full test list
//   op_done    engine -> sequencer completion pulse for the current select code
//   op_fail    engine -> sequencer mismatch flag, meaningful only with op_done
//   select     sequencer -> engine test code, 0 = idle / no test
//   busy       sequencer -> host   run in progress
//   done       sequencer -> host   last test completed (level, held)
//   pass       sequencer -> host   done with no failing test
//   fail_mask  sequencer -> host   bit k set = test code k failed or timed out
//   timeout    sequencer -> host   sticky, some test hit the watchdog
//
//   Modport master is the sequencer side; modport slave is the environment
//   (host plus engine) side.
// -----------------------------------------------------------------------------
interface bist_sequencer_if;
  logic       start;
  logic       op_done;
  logic       op_fail;
  logic [3:0] select;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_mask;
  logic       timeout;

  modport master (
    input  start, op_done, op_fail,
    output select, busy, done, pass, fail_mask, timeout
  );

  modport slave (
    output start, op_done, op_fail,
    input  select, busy, done, pass, fail_mask, timeout
  );
endinterface

// File: rtl/bist_sequencer.sv
// -----------------------------------------------------------------------------
// bist_sequencer
//   Walks a BIST engine through test codes FIRST_SEL..LAST_SEL. Each test is
//   issued on select, the engine answers with op_done/op_fail, the result is
//   accumulated in fail_mask, and GAP_CYCLES idle cycles (select = 0) separate
//   consecutive tests. Once the last test completes, done (and pass when no
//   test failed) is held until the next accepted start.
//
//   Ports:
//     clk   rising-edge clock for all logic
//     rst   synchronous, active-high reset
//     bus   bist_sequencer_if.master (start, op_done, op_fail in;
//           select, busy, done, pass, fail_mask, timeout out)
//
//   Every output is driven straight from a flop; no input reaches an output
//   combinationally.
//
//   Optional build macro BIST_SEQ_TIMEOUT_EN:
//     defined   - a 16-bit watchdog forces a failing completion of any test
//                 that runs TIMEOUT_CYCLES cycles without op_done and sets the
//                 sticky timeout flag. A real op_done in the expiry cycle wins.
//     undefined - no watchdog is built, timeout is tied 0 and a test waits
//                 for op_done indefinitely.
// -----------------------------------------------------------------------------
module bist_sequencer #(
  parameter int unsigned FIRST_SEL      = 1,    // first test code issued
  parameter int unsigned LAST_SEL       = 6,    // last test code, <= 7
  parameter int unsigned GAP_CYCLES     = 50,   // idle cycles between tests, 1..255
  parameter int unsigned TIMEOUT_CYCLES = 4096  // watchdog limit, 2..65535
) (
  input  logic             clk,
  input  logic             rst,
  bist_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] FIRST_CODE = 3'(FIRST_SEL);
  localparam logic [2:0] LAST_CODE  = 3'(LAST_SEL);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cur_q, cur_d;          // code of the test in flight / just finished
  logic [3:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] gap_q, gap_d;

  logic       complete;              // current test finishes on this edge
  logic       fail_bit;              // result recorded for it

`ifdef BIST_SEQ_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog_q, wdog_d;
  logic        tout_q, tout_d;
`endif

  // NOTE: every variable written here gets its default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    done_d   = done_q;
    mask_d   = mask_q;
    gap_d    = gap_q;
    complete = 1'b0;
    fail_bit = 1'b0;
`ifdef BIST_SEQ_TIMEOUT_EN
    wdog_d   = wdog_q;
    tout_d   = tout_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cur_d   = FIRST_CODE;
          sel_d   = {1'b0, FIRST_CODE};
          busy_d  = 1'b1;
          done_d  = 1'b0;
          mask_d  = '0;
`ifdef BIST_SEQ_TIMEOUT_EN
          wdog_d  = '0;
          tout_d  = 1'b0;
`endif
        end
      end

      S_RUN: begin
`ifdef BIST_SEQ_TIMEOUT_EN
        // A genuine answer in the expiry cycle takes precedence over the
        // watchdog, so its real op_fail is what gets recorded.
        if (bus.op_done) begin
          complete = 1'b1;
          fail_bit = bus.op_fail;
        end else if (wdog_q == WDOG_LAST) begin
          complete = 1'b1;
          fail_bit = 1'b1;
          tout_d   = 1'b1;
        end else if (wdog_q != 16'hFFFF) begin
          wdog_d = wdog_q + 16'd1;
        end
`else
        complete = bus.op_done;
        fail_bit = bus.op_fail;
`endif
        if (complete) begin
          mask_d[cur_q] = mask_q[cur_q] | fail_bit;
          sel_d         = '0;
          if (cur_q == LAST_CODE) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end

      S_GAP: begin
        // gap_q counts completed idle cycles; the GAP_CYCLES-th one launches
        // the next test so select sits at 0 for exactly GAP_CYCLES cycles.
        if (gap_q == GAP_LAST) begin
          state_d = S_RUN;
          cur_d   = cur_q + 3'd1;
          sel_d   = {1'b0, cur_q + 3'd1};
`ifdef BIST_SEQ_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end else if (gap_q != 8'hFF) begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // pass is registered from the next-state values so it changes on the same
    // edge as done and fail_mask.
    pass_d = done_d && (mask_d == 8'h00);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      gap_q   <= gap_d;
    end
  end

`ifdef BIST_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      tout_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tout_q <= tout_d;
    end
  end

  assign bus.timeout = tout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.select    = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = mask_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bist_sequencer
//   Directed bench for bist_sequencer with default parameters (codes 1..6,
//   50-cycle gaps, 4096-cycle watchdog). The bench plays host and engine; the
//   engine answers 20 cycles after each select change unless told otherwise.
//   Builds with or without BIST_SEQ_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_bist_sequencer;

  localparam int GAP  = 50;
  localparam int WDOG = 4096;
  localparam int RESP = 20;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bist_sequencer_if bus ();

  bist_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_select"},    bus.select,    0);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_done"},      bus.done,      0);
    check({tag, "_pass"},      bus.pass,      0);
    check({tag, "_fail_mask"}, bus.fail_mask, 0);
    check({tag, "_timeout"},   bus.timeout,   0);
  endtask

  task automatic check_end(input string tag, input logic [7:0] exp_mask,
                           input bit exp_pass, input bit exp_tout);
    check({tag, "_done"},      bus.done,      1);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_pass"},      bus.pass,      exp_pass);
    check({tag, "_fail_mask"}, bus.fail_mask, exp_mask);
    check({tag, "_timeout"},   bus.timeout,   exp_tout);
  endtask

  task automatic check_restart(input string tag);
    check({tag, "_select"},    bus.select,    1);
    check({tag, "_busy"},      bus.busy,      1);
    check({tag, "_done"},      bus.done,      0);
    check({tag, "_pass"},      bus.pass,      0);
    check({tag, "_fail_mask"}, bus.fail_mask, 0);
    check({tag, "_timeout"},   bus.timeout,   0);
  endtask

  // Plays the engine for one full run, starting just after the edge that
  // issued select=1.
  //   fails      op_fail value returned for each code k
  //   silent_sel code the engine never answers (0 = none)
  //   long_sel   code answered after WDOG cycles instead of RESP (0 = none)
  //   abort_k    reset 10 cycles into the gap after code abort_k (0 = none)
  //   inject     pulse start in the gap after 3 and in the run of 4, and a
  //              failing op_done inside every gap
  task automatic run_list(input logic [7:0] fails, input int silent_sel,
                          input int long_sel, input int abort_k, input bit inject);
    int n;
    for (int k = 1; k <= 6; k++) begin
      check("select_issued", bus.select, k);
      check("busy_in_run", bus.busy, 1);
      if (k == silent_sel) begin
        n = 0;
        while (bus.select == 4'(k) && n < 5000) begin
          tick;
          n++;
        end
`ifdef BIST_SEQ_TIMEOUT_EN
        check("watchdog_len", n, WDOG);
        check("timeout_set", bus.timeout, 1);
        check("timeout_mask_bit", bus.fail_mask[k], 1);
`else
        check("hang_len", n, 5000);
        check("hang_select", bus.select, k);
        check("timeout_tied", bus.timeout, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        return;
`endif
      end else begin
        for (int c = 1; c < ((k == long_sel) ? WDOG : RESP); c++) begin
          if (inject && k == 4 && c == 5) bus.start = 1'b1;
          tick;
          bus.start = 1'b0;
        end
        check("run_hold", bus.select, k);
        bus.op_done = 1'b1;
        bus.op_fail = fails[k];
        tick;
        bus.op_done = 1'b0;
        bus.op_fail = 1'b0;
        if (k == long_sel) begin
          check("late_done_timeout", bus.timeout, 0);
          check("late_done_mask_bit", bus.fail_mask[k], fails[k]);
        end
      end
      check("select_cleared", bus.select, 0);
      if (k < 6) begin
        check("busy_in_gap", bus.busy, 1);
        if (k == abort_k) begin
          repeat (10) tick;
          rst         = 1'b1;
          bus.op_done = 1'b1;
          bus.op_fail = 1'b1;
          tick;
          rst         = 1'b0;
          bus.op_done = 1'b0;
          bus.op_fail = 1'b0;
          return;
        end
        n = 0;
        while (bus.select == 4'd0 && n < 300) begin
          if (inject && k == 3 && n == 10) bus.start = 1'b1;
          if (inject && n == 20) begin
            bus.op_done = 1'b1;
            bus.op_fail = 1'b1;
          end
          tick;
          bus.start   = 1'b0;
          bus.op_done = 1'b0;
          bus.op_fail = 1'b0;
          n++;
        end
        check("gap_len", n, GAP);
      end else begin
        check("busy_end", bus.busy, 0);
        check("done_end", bus.done, 1);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op_done = 1'b0;
    bus.op_fail = 1'b0;
    tick;
    tick;
    check_reset_values("reset");
    rst = 1'b0;
    repeat (7) tick;

    // Clean run: every test passes.
    pulse_start;
    run_list(8'h00, 0, 0, 0, 1'b0);
    check_end("clean", 8'h00, 1'b1, 1'b0);

    // Tests 3 and 5 fail.
    pulse_start;
    run_list(8'h28, 0, 0, 0, 1'b0);
    check_end("fail35", 8'h28, 1'b0, 1'b0);

    // Engine activity while DONE is ignored.
    bus.op_done = 1'b1;
    bus.op_fail = 1'b1;
    tick;
    bus.op_done = 1'b0;
    bus.op_fail = 1'b0;
    check_end("done_ignore", 8'h28, 1'b0, 1'b0);

    // Start after done clears the previous result; ignored starts mid-run.
    pulse_start;
    check_restart("restart");
    run_list(8'h08, 0, 0, 0, 1'b1);
    check_end("inject", 8'h08, 1'b0, 1'b0);

    // Reset in the gap after test 3 with op_done held high; nothing survives.
    pulse_start;
    check_restart("pre_abort");
    run_list(8'h02, 0, 0, 3, 1'b0);
    check_reset_values("abort");
    pulse_start;
    check_restart("post_abort");

    // Test 1 answered in the last cycle before watchdog expiry.
    run_list(8'h00, 0, 1, 0, 1'b0);
    check_end("late_done", 8'h00, 1'b1, 1'b0);

    // Engine never answers test 2.
    pulse_start;
    run_list(8'h00, 2, 0, 0, 1'b0);
`ifdef BIST_SEQ_TIMEOUT_EN
    check_end("silent", 8'h04, 1'b0, 1'b1);
    pulse_start;
    check_restart("after_timeout");
`else
    check_reset_values("silent_reset");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
